// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply or restoring divide over magnitudes,
// with sign correction applied once at the end. Holds the pipeline while busy.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             invalidate,
   input  logic             start,
   input  logic [2:0]       fn3,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand for multiply, divisor for divide
   logic [WIDTH-1:0]   orig_q, orig_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // {high/remainder, low/quotient}
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic             sign_a, sign_b, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   msum, trial, diff;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0] quot_fix, rem_fix;

   assign sign_a = (fn3 == 3'd1) || (fn3 == 3'd2) || (fn3 == 3'd4) || (fn3 == 3'd6);
   assign sign_b = (fn3 == 3'd1) || (fn3 == 3'd4) || (fn3 == 3'd6);
   assign a_neg  = sign_a & rs1[WIDTH-1];
   assign b_neg  = sign_b & rs2[WIDTH-1];
   assign a_mag  = a_neg ? -rs1 : rs1;
   assign b_mag  = b_neg ? -rs2 : rs2;

   // Multiply step: conditional add into the high half, then shift the 65-bit pair right.
   assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {msum[WIDTH:1], msum[0], acc_q[WIDTH-1:1]};

   // Restoring divide step: shift next dividend bit into the remainder, subtract if it fits.
   assign trial    = acc_q[2*WIDTH-1:WIDTH-1];
   assign diff     = trial - {1'b0, opnd_q};
   assign div_next = diff[WIDTH] ? {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      orig_d   = orig_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      result_d = result_q;
      if (invalidate) begin
         state_d = StIdle;
      end else if (clk_en) begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StCalc;
                  cnt_d   = '0;
                  op_d    = fn3;
                  orig_d  = rs1;
                  neg_d   = a_neg ^ b_neg;
                  rneg_d  = a_neg;
                  dz_d    = fn3[2] && (rs2 == '0);
                  if (fn3[2]) begin
                     opnd_d = b_mag;
                     acc_d  = {{WIDTH{1'b0}}, a_mag};
                  end else begin
                     opnd_d = a_mag;
                     acc_d  = {{WIDTH{1'b0}}, b_mag};
                  end
               end
            end
            StCalc: begin
               acc_d = op_q[2] ? div_next : mul_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == {CNT_W{1'b1}}) state_d = StFix;
            end
            StFix: begin
               state_d = StDone;
               if (!op_q[2]) begin
                  result_d = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0]
                                                  : prod_fix[2*WIDTH-1:WIDTH];
               end else if (dz_q) begin
                  result_d = op_q[1] ? orig_q : {WIDTH{1'b1}};
               end else begin
                  result_d = op_q[1] ? rem_fix : quot_fix;
               end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         orig_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         orig_q   <= orig_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         result_q <= result_d;
      end
   end

   assign stall_req = ((state_q == StIdle) && start) || (state_q == StCalc) || (state_q == StFix);
   assign done      = (state_q == StDone);
   assign result    = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected result and done cycle are queued at issue
// and checked when done rises.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst, clk_en, invalidate, start;
   logic [2:0]  fn3;
   logic [31:0] rs1, rs2;
   logic        stall_req, done;
   logic [31:0] result;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   t0       = 0;
   logic done_prev = 1'b0;

   muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .invalidate(invalidate), .start(start),
      .fn3(fn3), .rs1(rs1), .rs2(rs2), .stall_req(stall_req), .done(done), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      done_prev <= done;
   end

   // Called at posedge+1; occupies the start cycle and returns one cycle later.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push, input int lat);
      exp_t e;
      fn3 = f; rs1 = a; rs2 = b; start = 1'b1;
      t0 = cyc;
      if (push) begin
         e.res = exp;
         e.cyc = cyc + lat;
         sb.push_back(e);
      end
      @(negedge clk);
      check("stall_on_start", {31'd0, stall_req}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      fn3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("timeout", 32'd1, 32'd0);
         sb.delete();
      end
      #1;
   endtask

   task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
      @(posedge clk); #1;
      issue(f, a, b, exp, 1'b1, 34);
      drain();
   endtask

   initial begin
      rst = 1'b1; clk_en = 1'b1; invalidate = 1'b0; start = 1'b0;
      fn3 = '0; rs1 = '0; rs2 = '0;
      #2;
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_stall", {31'd0, stall_req}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // MUL with stall/done timing
      @(posedge clk); #1;
      issue(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, 34);
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         check("stall_window", {31'd0, stall_req}, (k <= 33) ? 32'd1 : 32'd0);
         if (k < 34) check("done_early", {31'd0, done}, 32'd0);
      end
      drain();

      run(3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
      run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
      run(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
      run(3'd5, 32'd100, 32'd7, 32'd14);
      run(3'd7, 32'd100, 32'd7, 32'd2);
      run(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF);
      run(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF);
      run(3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
      run(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      run(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);
      run(3'd0, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080);

      // Invalidate in cycle 10, restart in cycle 11
      @(posedge clk); #1;
      issue(3'd5, 32'd100, 32'd7, 32'd0, 1'b0, 0);
      wait_until(t0 + 10);
      invalidate = 1'b1;
      @(posedge clk); #1;
      invalidate = 1'b0;
      check("inv_stall", {31'd0, stall_req}, 32'd0);
      check("inv_done", {31'd0, done}, 32'd0);
      issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 34);
      drain();

      // clk_en low for cycles 5-9
      @(posedge clk); #1;
      issue(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b1, 39);
      wait_until(t0 + 5);
      clk_en = 1'b0;
      wait_until(t0 + 10);
      clk_en = 1'b1;
      drain();

      // Async reset mid-operation: nothing may complete
      @(posedge clk); #1;
      issue(3'd4, 32'd1000, 32'd3, 32'd0, 1'b0, 0);
      wait_until(t0 + 20);
      rst = 1'b1;
      #1;
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_stall", {31'd0, stall_req}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_until(cyc + 50);

      run(3'd7, 32'd1000, 32'd3, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
